// File: rtl/usb_link_buf_arbiter_if.sv
// Endpoint-buffer bus between the application buffer logic and a USB core.
// The master drives addresses, data and the wren/commit/arm strobes. The slave
// returns ready, acks, read data and lengths.
// Every field is packed per channel, so channel c sits in slice [c*W +: W].
//   in_*  : IN (device-to-host) buffer write side
//   out_* : OUT (host-to-device) buffer read side
interface usb_link_buf_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 11
);
  logic [NUM_CH-1:0][ADDR_W-1:0] in_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] in_data;
  logic [NUM_CH-1:0]             in_wren;
  logic [NUM_CH-1:0]             in_commit;
  logic [NUM_CH-1:0][LEN_W-2:0]  in_commit_len;
  logic [NUM_CH-1:0]             in_ready;
  logic [NUM_CH-1:0]             in_commit_ack;
  logic [NUM_CH-1:0][ADDR_W-1:0] out_addr;
  logic [NUM_CH-1:0]             out_arm;
  logic [NUM_CH-1:0][DATA_W-1:0] out_q;
  logic [NUM_CH-1:0][LEN_W-1:0]  out_len;
  logic [NUM_CH-1:0]             out_hasdata;
  logic [NUM_CH-1:0]             out_arm_ack;

  modport master (
    output in_addr, in_data, in_wren, in_commit, in_commit_len, out_addr, out_arm,
    input  in_ready, in_commit_ack, out_q, out_len, out_hasdata, out_arm_ack
  );
  modport slave (
    input  in_addr, in_data, in_wren, in_commit, in_commit_len, out_addr, out_arm,
    output in_ready, in_commit_ack, out_q, out_len, out_hasdata, out_arm_ack
  );
endinterface

// File: rtl/usb_link_buf_arbiter.sv
// Hands the shared application endpoint buffers to exactly one USB core,
// either SuperSpeed (ss_buf) or High/Full-Speed (hs_buf). SS has priority.
// Before a core is released, outstanding commit and arm handshakes are drained.
// A HOLDOFF-cycle idle gap then separates the release from the next grant.
// Ports:
//   ext_clk, reset_n       : clock, synchronous active-low reset
//   ss_active, hs_active   : link-up indications used to choose the owner
//   app                    : application side of the buffer bus (slave)
//   ss_buf, hs_buf         : per-core buffer buses (master)
//   sel                    : owner 00 none / 01 HS / 10 SS
//   switching              : DRAIN or HOLD in progress
//   err_timeout, err_drop  : one-cycle error pulses
//   switch_cnt             : completed grants, saturating at 255

// Per-channel outstanding-handshake tracker. A set wins over a clear.
module usb_link_buf_arbiter_pend (
  input  logic ext_clk,
  input  logic reset_n,
  input  logic flush,
  input  logic set_commit,
  input  logic clr_commit,
  input  logic set_arm,
  input  logic clr_arm,
  output logic pend
);
  logic pend_commit, pend_arm;

  always_ff @(posedge ext_clk) begin
    if (!reset_n || flush) begin
      pend_commit <= 1'b0;
      pend_arm    <= 1'b0;
    end else begin
      if (set_commit)      pend_commit <= 1'b1;
      else if (clr_commit) pend_commit <= 1'b0;
      if (set_arm)         pend_arm    <= 1'b1;
      else if (clr_arm)    pend_arm    <= 1'b0;
    end
  end

  assign pend = pend_commit | pend_arm;
endmodule

module usb_link_buf_arbiter #(
  parameter int NUM_CH   = 2,
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 11,
  parameter int HOLDOFF  = 16,
  parameter int DRAIN_TO = 1024
) (
  input  logic                  ext_clk,
  input  logic                  reset_n,
  input  logic                  ss_active,
  input  logic                  hs_active,
  usb_link_buf_arbiter_if.slave  app,
  usb_link_buf_arbiter_if.master ss_buf,
  usb_link_buf_arbiter_if.master hs_buf,
  output logic [1:0]            sel,
  output logic                  switching,
  output logic                  err_timeout,
  output logic                  err_drop,
  output logic [7:0]            switch_cnt
);
  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_HS   = 2'b01;
  localparam logic [1:0] SEL_SS   = 2'b10;
  // One counter serves both the HOLD gap and the DRAIN timeout.
  localparam int CNT_W = $clog2((DRAIN_TO > HOLDOFF ? DRAIN_TO : HOLDOFF) + 1);

  typedef enum logic [2:0] {S_NONE, S_OWN_HS, S_OWN_SS, S_DRAIN, S_HOLD} state_t;

  state_t                        state, state_nxt;
  logic [1:0]                    sel_nxt, tgt;
  logic [CNT_W-1:0]              cnt;
  logic                          pending, drain_to_hit, hold_done, to_own;
  logic                          own_hs, own_ss, drop_any;
  logic [NUM_CH-1:0]             pend_ch, fwd_commit, fwd_arm;
  logic [NUM_CH-1:0]             ret_ready, ret_cack, ret_hasd, ret_aack;
  logic [NUM_CH-1:0][DATA_W-1:0] ret_q;
  logic [NUM_CH-1:0][LEN_W-1:0]  ret_len;
  logic [NUM_CH-1:0][ADDR_W-1:0] bc_in_addr, bc_out_addr;

  assign tgt = ss_active ? SEL_SS : (hs_active ? SEL_HS : SEL_NONE);

  // Timeout only applies when something is still outstanding.
  assign drain_to_hit = (state == S_DRAIN) && pending && (cnt == CNT_W'(DRAIN_TO - 1));
  assign hold_done    = (cnt == CNT_W'(HOLDOFF - 1));
  assign to_own       = (state_nxt != state) &&
                        (state_nxt == S_OWN_HS || state_nxt == S_OWN_SS);
  assign drop_any     = (state != S_OWN_HS) && (state != S_OWN_SS) &&
                        (|(app.in_commit | app.out_arm));

  // State register
  always_ff @(posedge ext_clk) begin
    if (!reset_n) begin
      state       <= S_NONE;
      sel         <= SEL_NONE;
      cnt         <= '0;
      err_timeout <= 1'b0;
      err_drop    <= 1'b0;
      switch_cnt  <= 8'd0;
    end else begin
      state       <= state_nxt;
      sel         <= sel_nxt;
      err_timeout <= drain_to_hit;
      err_drop    <= drop_any;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == S_DRAIN || state == S_HOLD)
        cnt <= cnt + 1'b1;
      if (to_own && switch_cnt != 8'hff)
        switch_cnt <= switch_cnt + 8'd1;
    end
  end

  // Next state. A target change during HOLD is only seen at the exit re-sample.
  always_comb begin
    state_nxt = state;
    case (state)
      S_NONE:             if (tgt != SEL_NONE) state_nxt = S_HOLD;
      S_OWN_HS, S_OWN_SS: if (tgt != sel) state_nxt = S_DRAIN;
      S_DRAIN:            if (!pending || drain_to_hit) state_nxt = S_HOLD;
      S_HOLD:
        if (hold_done) begin
          case (tgt)
            SEL_SS:  state_nxt = S_OWN_SS;
            SEL_HS:  state_nxt = S_OWN_HS;
            default: state_nxt = S_NONE;
          endcase
        end
      default:            state_nxt = S_NONE;
    endcase
  end

  // sel follows the next state. DRAIN keeps the old owner so its acks still return.
  always_comb begin
    case (state_nxt)
      S_OWN_HS: sel_nxt = SEL_HS;
      S_OWN_SS: sel_nxt = SEL_SS;
      S_DRAIN:  sel_nxt = sel;
      default:  sel_nxt = SEL_NONE;
    endcase
  end

  // Outputs. The strobe enables also depend on reset_n, so the strobes drop
  // in the same cycle that reset is asserted.
  assign switching = (state == S_DRAIN) || (state == S_HOLD);
  assign own_hs    = (state == S_OWN_HS) && reset_n;
  assign own_ss    = (state == S_OWN_SS) && reset_n;

  assign bc_in_addr  = app.in_addr;
  assign bc_out_addr = app.out_addr;

  always_comb begin
    hs_buf.in_addr       = bc_in_addr;
    hs_buf.in_data       = app.in_data;
    hs_buf.in_commit_len = app.in_commit_len;
    hs_buf.out_addr      = bc_out_addr;
    hs_buf.in_wren       = own_hs ? app.in_wren   : '0;
    hs_buf.in_commit     = own_hs ? app.in_commit : '0;
    hs_buf.out_arm       = own_hs ? app.out_arm   : '0;
  end

  always_comb begin
    ss_buf.in_addr       = bc_in_addr;
    ss_buf.in_data       = app.in_data;
    ss_buf.in_commit_len = app.in_commit_len;
    ss_buf.out_addr      = bc_out_addr;
    ss_buf.in_wren       = own_ss ? app.in_wren   : '0;
    ss_buf.in_commit     = own_ss ? app.in_commit : '0;
    ss_buf.out_arm       = own_ss ? app.out_arm   : '0;
  end

  always_comb begin
    ret_ready = '0;
    ret_cack  = '0;
    ret_hasd  = '0;
    ret_aack  = '0;
    ret_q     = '0;
    ret_len   = '0;
    case (sel)
      SEL_HS: begin
        ret_ready = hs_buf.in_ready;
        ret_cack  = hs_buf.in_commit_ack;
        ret_hasd  = hs_buf.out_hasdata;
        ret_aack  = hs_buf.out_arm_ack;
        ret_q     = hs_buf.out_q;
        ret_len   = hs_buf.out_len;
      end
      SEL_SS: begin
        ret_ready = ss_buf.in_ready;
        ret_cack  = ss_buf.in_commit_ack;
        ret_hasd  = ss_buf.out_hasdata;
        ret_aack  = ss_buf.out_arm_ack;
        ret_q     = ss_buf.out_q;
        ret_len   = ss_buf.out_len;
      end
      default: ;
    endcase
  end

  // In DRAIN, ready is held low so the app does not start new writes to a core
  // that is being released.
  assign app.in_ready      = ret_ready & {NUM_CH{state != S_DRAIN}};
  assign app.in_commit_ack = ret_cack;
  assign app.out_hasdata   = ret_hasd;
  assign app.out_arm_ack   = ret_aack;
  assign app.out_q         = ret_q;
  assign app.out_len       = ret_len;

  // Pending tracking, one tracker per channel.
  assign fwd_commit = app.in_commit & {NUM_CH{own_hs | own_ss}};
  assign fwd_arm    = app.out_arm   & {NUM_CH{own_hs | own_ss}};

  usb_link_buf_arbiter_pend u_pend [NUM_CH-1:0] (
    .ext_clk    (ext_clk),
    .reset_n    (reset_n),
    .flush      (drain_to_hit),
    .set_commit (fwd_commit),
    .clr_commit (ret_cack),
    .set_arm    (fwd_arm),
    .clr_arm    (ret_aack),
    .pend       (pend_ch)
  );

  assign pending = |pend_ch;
endmodule

// File: doc/usb_link_buf_arbiter.md
# usb_link_buf_arbiter

Parametrised arbiter that gives exactly one USB core, SuperSpeed (usb3) or High/Full-Speed (usb2), ownership of the shared application endpoint-buffer interface. It generalises the fixed single-endpoint dual-core top level to NUM_CH channels. It adds a link-priority state machine, drains outstanding commit and arm handshakes, and applies a hold-off guard before each ownership change. It sits between the application buffer logic and the two cores' `buf_in_*` and `buf_out_*` ports.

## Interface
Parameters:
- NUM_CH, 2: number of endpoint channels; legal range 1..8.
- ADDR_W, 9: buffer address width.
- DATA_W, 8: buffer data width.
- LEN_W, 11: length width. Commit length uses LEN_W-1 bits.
- HOLDOFF, 16: idle cycles between releasing one core and granting the next; must be at least 1.
- DRAIN_TO, 1024: maximum cycles spent waiting for pending handshakes.

Ports:
- ext_clk  in  1  single clock; every signal in this block is synchronous to it.
- reset_n  in  1  synchronous, active-low reset.
- ss_active / hs_active  in  1  usb3 link is in U0 / usb2 `stat_connected`.
- app_in_addr, app_in_data  in  NUM_CH*ADDR_W, NUM_CH*DATA_W  flattened per channel; channel c is in slice [c*W +: W].
- app_in_wren, app_in_commit, app_out_arm  in  NUM_CH  per-channel strobes.
- app_in_commit_len  in  NUM_CH*(LEN_W-1).
- app_out_addr  in  NUM_CH*ADDR_W.
- app_in_ready, app_in_commit_ack, app_out_hasdata, app_out_arm_ack  out  NUM_CH.
- app_out_q, app_out_len  out  NUM_CH*DATA_W, NUM_CH*LEN_W.
- ss_buf_* / hs_buf_*: one mirrored core-side set per core with the same widths. Core inputs are the app-side inputs; core outputs are the app-side outputs.
- sel  out  2  current owner: 00 none, 01 HS, 10 SS.
- switching  out  1  high while the state is DRAIN or HOLD.
- err_timeout  out  1  one-cycle pulse when the DRAIN_TO timeout expires.
- err_drop  out  1  one-cycle pulse when an app commit or arm is dropped.
- switch_cnt  out  8  number of completed grants; saturates at 255.

## Operation
- Target owner: SS if ss_active; otherwise HS if hs_active; otherwise NONE. SS always wins.
- States:
  - NONE: sel=00. When target is not NONE, go to HOLD.
  - OWN_HS / OWN_SS: sel=01 / 10. When target differs from the current owner, go to DRAIN.
  - DRAIN: sel keeps the old owner so that acks can still return. Go to HOLD when pending==0, or when the drain counter reaches DRAIN_TO-1 (this also clears pending and pulses err_timeout).
  - HOLD: sel=00. Counts HOLDOFF cycles, then re-samples target: SS goes to OWN_SS, HS goes to OWN_HS, NONE goes to NONE. Any transition into OWN_* increments switch_cnt.
- Forward path:
  - addr, data and commit_len are broadcast to both cores.
  - wren, commit and arm reach only the core selected by sel, and only in OWN_*. In every other state they are forced to 0 at both cores.
- Return path:
  - ready, commit_ack, q, len, hasdata and arm_ack are muxed from the core selected by sel. With sel=00 they are all 0.
  - app_in_ready is additionally forced to 0 while in DRAIN.
- Pending tracking:
  - pend_commit[c] is set by a forwarded commit and cleared by commit_ack[c] from the sel core.
  - pend_arm[c] is handled the same way with arm and arm_ack.
  - pending = OR of all pend_commit and pend_arm bits.
  - If a set and a clear occur in the same cycle, the set wins.
- Drop rule: an app commit or arm presented in DRAIN, HOLD or NONE is discarded and pulses err_drop. A single err_drop pulse covers any number of channels in the same cycle.

## Timing
- sel, state, pending, counters and error pulses are registered.
- All forward and return muxing is combinational from registered sel and state; there is zero added data latency.
- Target change to DRAIN entry: 1 cycle.
- DRAIN with pending==0: 1 cycle in DRAIN. HOLD lasts exactly HOLDOFF cycles.
- Minimum ownership changeover is HOLDOFF+2 cycles from the input change to the new sel.
- A target change during HOLD is not acted on early; it is resolved by the exit re-sample.
- Reset, including mid-operation: state=NONE, sel=00, pending=0, counters=0, switch_cnt=0, switching=0, error pulses 0, and all core strobes 0 in the same cycle as reset is applied.

## Test plan
- Reset, then hs_active=1 → sel=01 after HOLDOFF+1 cycles, switch_cnt=1, and wren/commit on ch0 appear only at hs_buf.
- While HS owns, commit ch1 (len=64) with ack withheld, then raise ss_active → DRAIN holds sel=01 and app_in_ready=0. Ack after 5 cycles → HOLD, then sel=10, switch_cnt=2.
- Pending commit that is never acked during a switch → err_timeout pulses after DRAIN_TO cycles; pending clears; SS is granted.
- app_out_arm ch0 while in HOLD → err_drop pulses once, both cores' arm stays 0, and pend_arm stays 0.
- ss_active and hs_active rise together from NONE → sel=10 (SS priority). hs_active drops afterwards → no switch occurs.
- reset_n low while in DRAIN with pending set → next cycle sel=00, pending=0, and all outputs are at their reset values.
